// File: rtl/cnn_window_gen_if.sv
// Pixel-in / window-out stream bundle for cnn_window_gen.
interface cnn_window_gen_if #(
  parameter int WIDTH = 9,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_pix;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] U1, U2, U3, U4, U5, U6, U7, U8, U9;
  logic [RW-1:0]           out_row;
  logic [CW-1:0]           out_col;
  logic                    out_last;

  modport master (
    output in_valid, in_pix, out_ready,
    input  in_ready, out_valid, U1, U2, U3, U4, U5, U6, U7, U8, U9,
           out_row, out_col, out_last
  );

  modport slave (
    input  in_valid, in_pix, out_ready,
    output in_ready, out_valid, U1, U2, U3, U4, U5, U6, U7, U8, U9,
           out_row, out_col, out_last
  );
endinterface

// File: rtl/cnn_window_gen.sv
// Zero-padded 3x3 window generator: two line buffers feed a column shift register,
// and each window is masked by its centre position before being registered.
module cnn_window_gen #(
  parameter int WIDTH = 9,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input logic             clk,
  input logic             rst_n,
  cnn_window_gen_if.slave bus
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] RMAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] CMAX = CW'(IMG_W - 1);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_e;
  state_e state_q, state_d;

  logic out_can, in_rdy, in_xfer, out_xfer, shift, step;
  logic [CW-1:0] in_col_q, in_col_d, cc_q, cc_d, ocol_q, ocol_d;
  logic [RW-1:0] in_row_q, in_row_d, cr_q, cr_d, orow_q, orow_d;
  logic [WIDTH-1:0] lb0_q [IMG_W];
  logic [WIDTH-1:0] lb1_q [IMG_W];
  logic [WIDTH-1:0] new_bot;
  logic [2:0][WIDTH-1:0] ca_q, ca_d, cb_q, cb_d, new_col;
  logic [8:0][WIDTH-1:0] u_q, u_d;
  logic ov_q, ov_d, last_q, last_d;
  logic m_top, m_bot, m_left, m_right;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (in_xfer && in_row_q == RW'(1) && in_col_q == '0) state_d = RUN;
      RUN:     if (in_xfer && in_row_q == RMAX && in_col_q == CMAX) state_d = FLUSH;
      FLUSH:   if (out_xfer && last_q) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // In FLUSH, virtual zero pixels keep the window advancing until the last one is out.
  always_comb begin
    out_can  = !ov_q || bus.out_ready;
    in_rdy   = (state_q != FLUSH) && out_can;
    in_xfer  = bus.in_valid && in_rdy;
    out_xfer = ov_q && bus.out_ready;
    shift    = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      FILL:    shift = in_xfer;
      RUN:     begin shift = in_xfer; step = in_xfer; end
      FLUSH:   begin step = out_can && !(ov_q && last_q); shift = step; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_xfer) begin
      lb1_q[in_col_q] <= lb0_q[in_col_q];
      lb0_q[in_col_q] <= bus.in_pix;
    end
  end

  // Window = previous two columns plus the incoming column; at a row wrap the
  // incoming column belongs to the next row but is masked off as the right edge.
  always_comb begin
    new_bot  = (state_q == FLUSH) ? '0 : bus.in_pix;
    new_col  = {new_bot, lb0_q[in_col_q], lb1_q[in_col_q]};
    m_top    = (cr_q == '0);
    m_bot    = (cr_q == RMAX);
    m_left   = (cc_q == '0);
    m_right  = (cc_q == CMAX);
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    cr_d     = cr_q;
    cc_d     = cc_q;
    orow_d   = orow_q;
    ocol_d   = ocol_q;
    ca_d     = ca_q;
    cb_d     = cb_q;
    u_d      = u_q;
    ov_d     = ov_q;
    last_d   = last_q;
    if (shift) begin
      ca_d     = cb_q;
      cb_d     = new_col;
      in_col_d = (in_col_q == CMAX) ? '0 : in_col_q + 1'b1;
      if (in_col_q == CMAX) in_row_d = (in_row_q == RMAX) ? '0 : in_row_q + 1'b1;
    end
    if (state_q == FLUSH && state_d == FILL) begin
      in_col_d = '0;
      in_row_d = '0;
    end
    if (step) begin
      u_d[0] = (m_top || m_left)  ? '0 : ca_q[0];
      u_d[1] = m_top              ? '0 : cb_q[0];
      u_d[2] = (m_top || m_right) ? '0 : new_col[0];
      u_d[3] = m_left             ? '0 : ca_q[1];
      u_d[4] = cb_q[1];
      u_d[5] = m_right            ? '0 : new_col[1];
      u_d[6] = (m_bot || m_left)  ? '0 : ca_q[2];
      u_d[7] = m_bot              ? '0 : cb_q[2];
      u_d[8] = (m_bot || m_right) ? '0 : new_col[2];
      ov_d   = 1'b1;
      last_d = m_bot && m_right;
      orow_d = cr_q;
      ocol_d = cc_q;
      cc_d   = m_right ? '0 : cc_q + 1'b1;
      if (m_right) cr_d = m_bot ? '0 : cr_q + 1'b1;
    end else if (out_xfer) begin
      ov_d   = 1'b0;
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_col_q <= '0;
      in_row_q <= '0;
      cr_q     <= '0;
      cc_q     <= '0;
      orow_q   <= '0;
      ocol_q   <= '0;
      ca_q     <= '0;
      cb_q     <= '0;
      u_q      <= '0;
      ov_q     <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      in_col_q <= in_col_d;
      in_row_q <= in_row_d;
      cr_q     <= cr_d;
      cc_q     <= cc_d;
      orow_q   <= orow_d;
      ocol_q   <= ocol_d;
      ca_q     <= ca_d;
      cb_q     <= cb_d;
      u_q      <= u_d;
      ov_q     <= ov_d;
      last_q   <= last_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = ov_q;
  assign bus.out_last  = last_q;
  assign bus.out_row   = orow_q;
  assign bus.out_col   = ocol_q;
  assign bus.U1 = u_q[0];
  assign bus.U2 = u_q[1];
  assign bus.U3 = u_q[2];
  assign bus.U4 = u_q[3];
  assign bus.U5 = u_q[4];
  assign bus.U6 = u_q[5];
  assign bus.U7 = u_q[6];
  assign bus.U8 = u_q[7];
  assign bus.U9 = u_q[8];
endmodule
